// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer for the RV32I-subset datapath: steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB over a shared, handshaked memory port and traps on errors.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT   = 16,
  parameter int unsigned INSTRET_W = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [6:0]           opcode_i,
  input  logic                 branch_taken_i,
  input  logic                 mem_ack_i,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic                 mem_sel_o,
  output logic                 ir_we_o,
  output logic                 pc_we_o,
  output logic                 pc_src_o,
  output logic                 alusrc_o,
  output logic                 rf_we_o,
  output logic                 wb_sel_o,
  output logic [2:0]           state_o,
  output logic [INSTRET_W-1:0] instret_o,
  output logic [1:0]           err_code_o
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_EXECUTE = 3'd3,
    ST_MEM     = 3'd4,
    ST_WB      = 3'd5,
    ST_ERROR   = 3'd7
  } state_e;

  typedef enum logic [2:0] {
    CLS_R,
    CLS_I,
    CLS_LOAD,
    CLS_STORE,
    CLS_BRANCH
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e                 state_q, state_d;
  cls_e                   cls_q, cls_d;
  logic [1:0]             err_q, err_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;

  cls_e                   op_cls;
  logic                   op_legal;
  logic                   retire;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    op_cls   = CLS_R;
    op_legal = 1'b1;
    case (opcode_i)
      OP_R:      op_cls = CLS_R;
      OP_I:      op_cls = CLS_I;
      OP_LOAD:   op_cls = CLS_LOAD;
      OP_STORE:  op_cls = CLS_STORE;
      OP_BRANCH: op_cls = CLS_BRANCH;
      default:   op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cls_q     <= CLS_R;
      err_q     <= ERR_NONE;
      cnt_q     <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cls_d     = cls_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    instret_d = instret_q;
    retire    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_FETCH;
          cnt_d   = '0;
        end
      end
      ST_FETCH: begin
        if (mem_ack_i) begin
          state_d = ST_DECODE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DECODE: begin
        if (op_legal) begin
          state_d = ST_EXECUTE;
          cls_d   = op_cls;
        end else begin
          state_d = ST_ERROR;
          err_d   = ERR_ILLEGAL;
        end
      end
      ST_EXECUTE: begin
        case (cls_q)
          CLS_R, CLS_I:        state_d = ST_WB;
          CLS_LOAD, CLS_STORE: begin
            state_d = ST_MEM;
            cnt_d   = '0;
          end
          CLS_BRANCH:          retire = 1'b1;
          default: begin
            state_d = ST_ERROR;
            err_d   = ERR_ILLEGAL;
          end
        endcase
      end
      ST_MEM: begin
        if (mem_ack_i) begin
          if (cls_q == CLS_STORE) retire  = 1'b1;
          else                    state_d = ST_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_ERROR;
          err_d   = ERR_TIMEOUT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WB:    retire = 1'b1;
      ST_ERROR: state_d = ST_ERROR;
      default: begin
        state_d = ST_ERROR;
        err_d   = ERR_ILLEGAL;
      end
    endcase

    // start_i is only sampled at the instruction boundary.
    if (retire) begin
      instret_d = instret_q + INSTRET_W'(1);
      state_d   = start_i ? ST_FETCH : ST_IDLE;
      cnt_d     = '0;
    end
  end

  always_comb begin
    mem_req_o = 1'b0;
    mem_we_o  = 1'b0;
    mem_sel_o = 1'b0;
    ir_we_o   = 1'b0;
    pc_we_o   = 1'b0;
    pc_src_o  = 1'b0;
    alusrc_o  = 1'b0;
    rf_we_o   = 1'b0;
    wb_sel_o  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        mem_req_o = 1'b1;
        ir_we_o   = mem_ack_i;
        pc_we_o   = mem_ack_i;
      end
      ST_EXECUTE: begin
        alusrc_o = (cls_q == CLS_I) || (cls_q == CLS_LOAD) || (cls_q == CLS_STORE);
        if (cls_q == CLS_BRANCH) begin
          pc_we_o  = branch_taken_i;
          pc_src_o = branch_taken_i;
        end
      end
      ST_MEM: begin
        mem_req_o = 1'b1;
        mem_sel_o = 1'b1;
        mem_we_o  = (cls_q == CLS_STORE);
      end
      ST_WB: begin
        rf_we_o  = 1'b1;
        wb_sel_o = (cls_q == CLS_LOAD);
      end
      default: ;
    endcase
  end

  assign state_o    = state_q;
  assign instret_o  = instret_q;
  assign err_code_o = err_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: a per-cycle vector table for the main instruction flows,
// then hand-written sequences for illegal opcode, timeout, reset abort and counter wrap.
module tb_multicycle_ctrl;

  localparam int TMO = 16;
  localparam int IW  = 4;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ST  = 7'b0100011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  // Strobe bundle order: req, we, sel, ir_we, pc_we, pc_src, alusrc, rf_we, wb_sel
  localparam logic [8:0] S_NONE   = 9'b000000000;
  localparam logic [8:0] S_F_WAIT = 9'b100000000;
  localparam logic [8:0] S_F_ACK  = 9'b100110000;
  localparam logic [8:0] S_ALUS   = 9'b000000100;
  localparam logic [8:0] S_BR_T   = 9'b000011000;
  localparam logic [8:0] S_MEM_RD = 9'b101000000;
  localparam logic [8:0] S_MEM_WR = 9'b111000000;
  localparam logic [8:0] S_WB_ALU = 9'b000000010;
  localparam logic [8:0] S_WB_MEM = 9'b000000011;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic [6:0]    opcode_i;
  logic          branch_taken_i;
  logic          mem_ack_i;
  logic          mem_req_o, mem_we_o, mem_sel_o, ir_we_o, pc_we_o, pc_src_o;
  logic          alusrc_o, rf_we_o, wb_sel_o;
  logic [2:0]    state_o;
  logic [IW-1:0] instret_o;
  logic [1:0]    err_code_o;
  logic [8:0]    strb;

  int n_vec = 0;
  int n_bad = 0;

  multicycle_ctrl #(.TIMEOUT(TMO), .INSTRET_W(IW)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .opcode_i       (opcode_i),
    .branch_taken_i (branch_taken_i),
    .mem_ack_i      (mem_ack_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_sel_o      (mem_sel_o),
    .ir_we_o        (ir_we_o),
    .pc_we_o        (pc_we_o),
    .pc_src_o       (pc_src_o),
    .alusrc_o       (alusrc_o),
    .rf_we_o        (rf_we_o),
    .wb_sel_o       (wb_sel_o),
    .state_o        (state_o),
    .instret_o      (instret_o),
    .err_code_o     (err_code_o)
  );

  always #5 clk_i = ~clk_i;

  assign strb = {mem_req_o, mem_we_o, mem_sel_o, ir_we_o, pc_we_o, pc_src_o,
                 alusrc_o, rf_we_o, wb_sel_o};

  typedef struct {
    logic          start;
    logic [6:0]    op;
    logic          bt;
    logic          ack;
    logic [2:0]    st;
    logic [8:0]    strb;
    logic [IW-1:0] inst;
    logic [1:0]    err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic start, logic [6:0] op, logic bt, logic ack,
                              logic [2:0] st, logic [8:0] s, logic [IW-1:0] inst,
                              logic [1:0] err);
    vec_t v;
    v.start = start; v.op = op; v.bt = bt; v.ack = ack;
    v.st = st; v.strb = s; v.inst = inst; v.err = err;
    return v;
  endfunction

  task automatic drive(input logic start, input logic [6:0] op, input logic bt, input logic ack);
    start_i        = start;
    opcode_i       = op;
    branch_taken_i = bt;
    mem_ack_i      = ack;
  endtask

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs are driven just after the falling edge and outputs sampled 2 time units later.
  task automatic apply(input vec_t v, input int idx);
    drive(v.start, v.op, v.bt, v.ack);
    #2;
    n_vec++;
    if (state_o !== v.st || strb !== v.strb || instret_o !== v.inst || err_code_o !== v.err) begin
      n_bad++;
      $display("FAIL vec%0d: state=%0d strb=%b inst=%0d err=%0d, expected state=%0d strb=%b inst=%0d err=%0d",
               idx, state_o, strb, instret_o, err_code_o, v.st, v.strb, v.inst, v.err);
    end
    step();
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    drive(1'b0, OP_R, 1'b0, 1'b0);
    repeat (2) step();
    rst_ni = 1'b1;
  endtask

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, OP_R, 1'b0, 1'b0);
    #1;
    check("reset_state", {state_o, strb, instret_o, err_code_o}, {3'd0, S_NONE, 4'd0, 2'd0});
    step();
    rst_ni = 1'b1;

    // R with zero-wait fetch
    vecs.push_back(mk(0, OP_R,  0, 0, 0, S_NONE,   0, 0));
    vecs.push_back(mk(1, OP_R,  0, 0, 0, S_NONE,   0, 0));
    vecs.push_back(mk(1, OP_R,  0, 1, 1, S_F_ACK,  0, 0));
    vecs.push_back(mk(1, OP_R,  0, 1, 2, S_NONE,   0, 0));
    vecs.push_back(mk(1, OP_R,  0, 0, 3, S_NONE,   0, 0));
    vecs.push_back(mk(1, OP_R,  0, 0, 5, S_WB_ALU, 0, 0));
    // LOAD, two wait cycles in FETCH and in MEM
    vecs.push_back(mk(1, OP_LD, 0, 0, 1, S_F_WAIT, 1, 0));
    vecs.push_back(mk(1, OP_LD, 0, 0, 1, S_F_WAIT, 1, 0));
    vecs.push_back(mk(1, OP_LD, 0, 1, 1, S_F_ACK,  1, 0));
    vecs.push_back(mk(1, OP_LD, 0, 0, 2, S_NONE,   1, 0));
    vecs.push_back(mk(1, OP_LD, 0, 0, 3, S_ALUS,   1, 0));
    vecs.push_back(mk(1, OP_LD, 0, 0, 4, S_MEM_RD, 1, 0));
    vecs.push_back(mk(1, OP_LD, 0, 0, 4, S_MEM_RD, 1, 0));
    vecs.push_back(mk(1, OP_LD, 0, 1, 4, S_MEM_RD, 1, 0));
    vecs.push_back(mk(1, OP_LD, 0, 0, 5, S_WB_MEM, 1, 0));
    // STORE then taken BRANCH
    vecs.push_back(mk(1, OP_ST, 0, 1, 1, S_F_ACK,  2, 0));
    vecs.push_back(mk(1, OP_ST, 0, 0, 2, S_NONE,   2, 0));
    vecs.push_back(mk(1, OP_ST, 0, 0, 3, S_ALUS,   2, 0));
    vecs.push_back(mk(1, OP_ST, 0, 1, 4, S_MEM_WR, 2, 0));
    vecs.push_back(mk(1, OP_BR, 1, 1, 1, S_F_ACK,  3, 0));
    vecs.push_back(mk(1, OP_BR, 1, 0, 2, S_NONE,   3, 0));
    vecs.push_back(mk(1, OP_BR, 1, 0, 3, S_BR_T,   3, 0));
    // not-taken BRANCH
    vecs.push_back(mk(1, OP_BR, 0, 1, 1, S_F_ACK,  4, 0));
    vecs.push_back(mk(1, OP_BR, 0, 0, 2, S_NONE,   4, 0));
    vecs.push_back(mk(1, OP_BR, 0, 0, 3, S_NONE,   4, 0));
    // I-type with start dropped mid-instruction; stray acks are ignored
    vecs.push_back(mk(1, OP_I,  0, 1, 1, S_F_ACK,  5, 0));
    vecs.push_back(mk(0, OP_I,  0, 1, 2, S_NONE,   5, 0));
    vecs.push_back(mk(0, OP_I,  0, 1, 3, S_ALUS,   5, 0));
    vecs.push_back(mk(0, OP_I,  0, 0, 5, S_WB_ALU, 5, 0));
    vecs.push_back(mk(0, OP_I,  0, 1, 0, S_NONE,   6, 0));
    vecs.push_back(mk(0, OP_I,  0, 0, 0, S_NONE,   6, 0));

    foreach (vecs[i]) apply(vecs[i], i);

    // Illegal opcode from IDLE with instret already at 6
    drive(1'b1, OP_BAD, 1'b0, 1'b0); step();
    drive(1'b1, OP_BAD, 1'b0, 1'b1); #2;
    check("ill_fetch", {state_o, ir_we_o}, {3'd1, 1'b1});
    step();
    drive(1'b1, OP_BAD, 1'b0, 1'b0); #2;
    check("ill_decode", state_o, 3'd2);
    step(); #2;
    check("ill_error", {state_o, err_code_o, instret_o}, {3'd7, 2'd1, 4'd6});
    for (int i = 0; i < 20; i++) begin
      step();
      drive(1'b1, OP_R, 1'b1, 1'b1); #2;
      check("ill_sticky", {state_o, strb, instret_o, err_code_o}, {3'd7, S_NONE, 4'd6, 2'd1});
    end
    rst_ni = 1'b0; #1;
    check("ill_reset", {state_o, strb, instret_o, err_code_o}, {3'd0, S_NONE, 4'd0, 2'd0});
    step();
    rst_ni = 1'b1;

    // Fetch timeout: 16 unacknowledged request cycles
    do_reset();
    drive(1'b1, OP_R, 1'b0, 1'b0); step();
    for (int i = 1; i <= TMO; i++) begin
      #2;
      check("tmo_wait", {state_o, strb}, {3'd1, S_F_WAIT});
      step();
    end
    #2;
    check("tmo_error", {state_o, strb, err_code_o}, {3'd7, S_NONE, 2'd2});

    // Ack on the 16th cycle wins over the timeout
    do_reset();
    drive(1'b1, OP_R, 1'b0, 1'b0); step();
    for (int i = 1; i < TMO; i++) step();
    drive(1'b1, OP_R, 1'b0, 1'b1); #2;
    check("tmo_last_ack", {state_o, strb}, {3'd1, S_F_ACK});
    step();
    drive(1'b1, OP_R, 1'b0, 1'b0); #2;
    check("tmo_last_ok", {state_o, err_code_o}, {3'd2, 2'd0});

    // Reset asserted during MEM drops the request at once
    do_reset();
    drive(1'b1, OP_LD, 1'b0, 1'b0); step();
    drive(1'b1, OP_LD, 1'b0, 1'b1); step();
    drive(1'b1, OP_LD, 1'b0, 1'b0); step();
    step(); #2;
    check("rst_mem_before", {state_o, strb}, {3'd4, S_MEM_RD});
    #1 rst_ni = 1'b0; #1;
    check("rst_mem_after", {state_o, strb, err_code_o}, {3'd0, S_NONE, 2'd0});
    step();
    rst_ni = 1'b1;

    // 16 zero-wait branches wrap the 4-bit counter
    do_reset();
    drive(1'b1, OP_BR, 1'b0, 1'b1); step();
    for (int k = 1; k <= 16; k++) begin
      repeat (3) step();
      #2;
      check("wrap_cnt", {state_o, instret_o}, {3'd1, (k == 16) ? 4'd0 : 4'(k)});
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
